// File: rtl/clk_ratio_sched_if.sv
// Config handshake bundle for clk_ratio_sched.
// The host offers a new half-period ratio on cfg_valid/cfg_ratio.
// The scheduler answers with cfg_ready.
interface clk_ratio_sched_if #(
  parameter int RATIO_W = 8
) ();
  logic               cfg_valid;
  logic [RATIO_W-1:0] cfg_ratio;
  logic               cfg_ready;

  modport master (output cfg_valid, output cfg_ratio, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ratio, output cfg_ready);
endinterface

// File: rtl/clk_ratio_sched.sv
// clk_ratio_sched: run/stop and ratio controller for the divided slow clock.
//
// clock_slower toggles every active_ratio cycles of original_clock, so one slow
// period lasts 2*active_ratio cycles. tick marks each toggle.
// Ratio changes (SWITCH) and stops (STOP) are deferred to the next 1->0 edge of
// clock_slower. As a result, the slow domain only ever sees complete periods.
//
// Optional build macro CLK_RATIO_SCHED_STATS_EN adds period_cnt. period_cnt is a
// 32-bit count of completed slow periods.
module clk_ratio_sched #(
  parameter int RATIO_W       = 8,
  parameter int DEFAULT_RATIO = 5
) (
  input  logic               original_clock,
  input  logic               reset_in,
  input  logic               run_req,
  clk_ratio_sched_if.slave   cfg,
  output logic [RATIO_W-1:0] active_ratio,
  output logic               clock_slower,
  output logic               tick,
  output logic               busy,
  output logic               cfg_err
`ifdef CLK_RATIO_SCHED_STATS_EN
  ,
  output logic [31:0]        period_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    SWITCH = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam logic [RATIO_W-1:0] RATIO_ZERO = {RATIO_W{1'b0}};
  localparam logic [RATIO_W-1:0] RATIO_ONE  = RATIO_W'(1);
  localparam logic [RATIO_W-1:0] RATIO_DEF  = RATIO_W'(DEFAULT_RATIO);

  state_e             state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [RATIO_W-1:0] pending_q, pending_d;
  logic               clk_slow_q, clk_slow_d;
  logic               tick_q, tick_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               cfg_ready_s;
  logic               xfer_s;
  logic               xfer_ok_s;
  logic               xfer_bad_s;
  logic               toggle_s;
  logic               boundary_s;

  // Config is accepted only in IDLE and RUN, so a pending ratio can never be overwritten.
  assign cfg_ready_s = (state_q == IDLE) || (state_q == RUN);
  assign xfer_s      = cfg.cfg_valid & cfg_ready_s;
  assign xfer_ok_s   = xfer_s & (cfg.cfg_ratio != RATIO_ZERO);
  assign xfer_bad_s  = xfer_s & (cfg.cfg_ratio == RATIO_ZERO);
  // cnt never exceeds ratio-1, so an equality compare is enough to find the toggle cycle.
  assign toggle_s    = (state_q != IDLE) && (cnt_q == (ratio_q - RATIO_ONE));
  assign boundary_s  = toggle_s & clk_slow_q;

  // Half-period counter, clock toggle and tick, plus the state/ratio/error next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_slow_d = clk_slow_q;
    tick_d     = 1'b0;
    ratio_d    = ratio_q;
    pending_d  = pending_q;

    if (xfer_bad_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (state_q == IDLE) begin
      cnt_d      = RATIO_ZERO;
      clk_slow_d = 1'b0;
    end else if (toggle_s) begin
      cnt_d      = RATIO_ZERO;
      clk_slow_d = ~clk_slow_q;
      tick_d     = 1'b1;
    end else begin
      cnt_d = cnt_q + RATIO_ONE;
    end

    case (state_q)
      IDLE: begin
        // A ratio accepted together with run_req already governs the first period.
        if (xfer_ok_s) begin
          ratio_d = cfg.cfg_ratio;
        end else begin
          ratio_d = ratio_q;
        end
        if (run_req) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A ratio change outranks a stop request; SWITCH re-evaluates run_req at the boundary.
        if (xfer_ok_s) begin
          pending_d = cfg.cfg_ratio;
          state_d   = SWITCH;
        end else if (!run_req) begin
          state_d = STOP;
        end else begin
          state_d = RUN;
        end
      end
      SWITCH: begin
        if (boundary_s) begin
          ratio_d   = pending_q;
          pending_d = RATIO_ZERO;
          state_d   = run_req ? RUN : IDLE;
        end else begin
          state_d = SWITCH;
        end
      end
      STOP: begin
        // run_req returning before the falling edge simply resumes; the count never paused.
        if (run_req) begin
          state_d = RUN;
        end else if (boundary_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset that also drops any pending ratio.
  always_ff @(posedge original_clock) begin
    if (reset_in) begin
      state_q    <= IDLE;
      cnt_q      <= RATIO_ZERO;
      ratio_q    <= RATIO_DEF;
      pending_q  <= RATIO_ZERO;
      clk_slow_q <= 1'b0;
      tick_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      pending_q  <= pending_d;
      clk_slow_q <= clk_slow_d;
      tick_q     <= tick_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_s;
  assign active_ratio  = ratio_q;
  assign clock_slower  = clk_slow_q;
  assign tick          = tick_q;
  assign busy          = busy_q;
  assign cfg_err       = err_q;

`ifdef CLK_RATIO_SCHED_STATS_EN
  logic [31:0] pcnt_q, pcnt_d;

  // Completed-period counter; boundaries never occur in IDLE, so it holds there.
  always_comb begin
    if (boundary_s) begin
      pcnt_d = pcnt_q + 32'd1;
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Period counter register.
  always_ff @(posedge original_clock) begin
    if (reset_in) begin
      pcnt_q <= 32'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  assign period_cnt = pcnt_q;
`endif

endmodule
